// File: rtl/poly_shift_reg.sv
// WIDTH-bit polynomial counter with XNOR feedback, selectable long/short length,
// parallel load, synchronous clear and optional lock-up recovery. State moves on falling clk.
module poly_shift_reg #(
  parameter int unsigned      WIDTH          = 17,
  parameter int unsigned      SHORT_WIDTH    = 9,
  parameter logic [WIDTH-1:0] TAPS_LONG      = 17'h12000,
  parameter logic [WIDTH-1:0] TAPS_SHORT     = 17'h00110,
  parameter bit               LOCKUP_RECOVER = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enn,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             shift,
  input  logic             short_mode,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             lockup
);

  localparam logic [WIDTH-1:0] ShortMask = {{(WIDTH - SHORT_WIDTH){1'b0}}, {SHORT_WIDTH{1'b1}}};

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] active_mask;
  logic [WIDTH-1:0] taps;
  logic [WIDTH-1:0] shifted;
  logic             fb;

  always_comb begin
    active_mask = short_mode ? ShortMask : {WIDTH{1'b1}};
    taps        = short_mode ? TAPS_SHORT : TAPS_LONG;
    fb          = ~^(q_q & taps);
    // Masking after the shift both truncates to the active length and clears the upper bits.
    shifted     = {q_q[WIDTH-2:0], fb} & active_mask;
    lockup      = (q_q & active_mask) == active_mask;
    sout        = short_mode ? q_q[SHORT_WIDTH-1] : q_q[WIDTH-1];
  end

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (enn && ld) begin
      q_d = d & active_mask;
    end else if (enn && shift) begin
      q_d = (LOCKUP_RECOVER && lockup) ? '0 : shifted;
    end
  end

  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_poly_shift_reg.sv
// Directed bench for poly_shift_reg: reset, shifting, priority, short mode, lock-up and
// mode switching, with a recovering and a non-recovering instance side by side.
module tb_poly_shift_reg;

  localparam int unsigned W = 17;

  logic         clk = 1'b1;
  logic         rstn = 1'b0;
  logic         enn = 1'b0;
  logic         clr = 1'b0;
  logic         ld = 1'b0;
  logic         shift = 1'b0;
  logic         short_mode = 1'b0;
  logic [W-1:0] d = '0;
  logic [W-1:0] q1, q2;
  logic         sout1, sout2, lockup1, lockup2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  poly_shift_reg #(
    .WIDTH         (17),
    .SHORT_WIDTH   (9),
    .TAPS_LONG     (17'h12000),
    .TAPS_SHORT    (17'h00110),
    .LOCKUP_RECOVER(1'b1)
  ) u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .enn       (enn),
    .clr       (clr),
    .ld        (ld),
    .d         (d),
    .shift     (shift),
    .short_mode(short_mode),
    .q         (q1),
    .sout      (sout1),
    .lockup    (lockup1)
  );

  poly_shift_reg #(
    .WIDTH         (17),
    .SHORT_WIDTH   (9),
    .TAPS_LONG     (17'h12000),
    .TAPS_SHORT    (17'h00110),
    .LOCKUP_RECOVER(1'b0)
  ) u_dut_norec (
    .clk       (clk),
    .rstn      (rstn),
    .enn       (enn),
    .clr       (clr),
    .ld        (ld),
    .d         (d),
    .shift     (shift),
    .short_mode(short_mode),
    .q         (q2),
    .sout      (sout2),
    .lockup    (lockup2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Active edge is falling; sample 1 time unit after it.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  logic [W-1:0] model;
  int           first_zero;
  int           upper_bad;
  int           lock_seen;

  initial begin
    #3;
    check("reset_q", q1, 0);
    check("reset_sout", sout1, 0);
    check("reset_lockup", lockup1, 0);
    rstn = 1'b1;
    tick();
    check("release_hold", q1, 0);

    enn = 1'b1; shift = 1'b1;
    tick(); check("shift1", q1, 17'h00001);
    tick(); check("shift2", q1, 17'h00003);
    tick(); check("shift3", q1, 17'h00007);
    tick(); check("shift4", q1, 17'h0000F);

    // Asynchronous reset between falling edges.
    shift = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0; #1;
    check("async_reset", q1, 0);
    rstn = 1'b1;
    tick();

    enn = 1'b1; ld = 1'b1; shift = 1'b1; d = 17'h0ABCD;
    tick(); check("load_over_shift", q1, 17'h0ABCD);
    enn = 1'b0; ld = 1'b0; shift = 1'b1;
    tick(); check("enn_low_hold", q1, 17'h0ABCD);
    clr = 1'b1; ld = 1'b1; shift = 1'b1;
    tick(); check("clr_priority", q1, 0);
    clr = 1'b0; ld = 1'b0;

    // Long-mode run against a reference polynomial model.
    enn = 1'b1; shift = 1'b1; model = '0; lock_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      model = {model[W-2:0], ~^(model & 17'h12000)};
      tick();
      if (lockup1) lock_seen++;
      if (i % 50 == 49) check($sformatf("long_step%0d", i + 1), q1, model);
    end
    check("long_no_lockup", lock_seen, 0);

    // Short period from reset.
    shift = 1'b0;
    rstn = 1'b0; #1; rstn = 1'b1;
    short_mode = 1'b1; shift = 1'b1;
    first_zero = -1; upper_bad = 0;
    for (int i = 1; i <= 600; i++) begin
      tick();
      if (q1[16:9] != 0) upper_bad++;
      if (q1 == 0) begin
        first_zero = i;
        break;
      end
    end
    check("short_period", first_zero, 511);
    check("short_upper_zero", upper_bad, 0);

    shift = 1'b0; ld = 1'b1; d = 17'h1FFFF;
    tick();
    check("short_load_q", q1, 17'h001FF);
    check("short_load_lockup", lockup1, 1);
    check("short_load_sout", sout1, 1);

    short_mode = 1'b0; d = 17'h1FFFF;
    tick();
    check("long_ones_q", q1, 17'h1FFFF);
    check("long_ones_lockup", lockup1, 1);
    ld = 1'b0; shift = 1'b1;
    tick();
    check("recover_q", q1, 0);
    check("norec_q", q2, 17'h1FFFF);
    check("norec_lockup", lockup2, 1);

    // Lock-up flag follows short_mode combinationally.
    shift = 1'b0; ld = 1'b1; d = 17'h001FF;
    tick();
    check("long_1ff_lockup", lockup1, 0);
    short_mode = 1'b1; #1;
    check("short_1ff_lockup", lockup1, 1);

    short_mode = 1'b0; d = 17'h1F000;
    tick();
    check("switch_long_sout", sout1, 1);
    short_mode = 1'b1; #1;
    check("switch_short_sout", sout1, 0);
    ld = 1'b0; shift = 1'b1;
    tick();
    check("switch_q", q1, 17'h00001);
    check("switch_sout", sout1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
